east_west_arbiter: RTL
======================

Name: east_west_arbiter

Overview:
- Two-requester arbiter (East/West) for a single shared resource, e.g. the shared lane driven by the two-flip-flop E/W state logic.
- Grants exclusive access to one side at a time.
- Enforces a maximum tenure when the other side is waiting, round-robin on ties, and a fixed all-clear gap between grants.
- Sits between the requester logic and the shared-resource enables; all outputs are registered.

Parameters:
- HOLD_CYCLES, 4, max grant cycles while the opposite side is requesting (legal ≥ 1).
- CLEAR_CYCLES, 2, all-clear gap cycles after every grant release (legal ≥ 1).
- CNT_W, 8, width of the tenure/gap counter and the optional statistics counters.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- req_e  input  1  East request, level, held until served.
- req_w  input  1  West request, level.
- gnt_e  output  1  East grant, registered.
- gnt_w  output  1  West grant, registered.
- all_clear  output  1  high when neither side is granted (IDLE or CLEAR).
- last_e  output  1  1 = East was the most recently granted side.
- grant_cnt_e  output  CNT_W  East grant count (optional feature).
- grant_cnt_w  output  CNT_W  West grant count (optional feature).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset: state = IDLE, gnt_e = 0, gnt_w = 0, all_clear = 1, last_e = 0 (East wins the first tie), counter = 0, stats = 0.
- Reset asserted mid-grant: the grant drops on that same edge; no CLEAR gap is inserted.
- States: IDLE, GNT_E, GNT_W, CLEAR.
- Arbitration decision, used in IDLE and on the final CLEAR cycle:
  - Only req_e high → GNT_E.
  - Only req_w high → GNT_W.
  - Both high → the side opposite last_e (last_e = 0 → East, last_e = 1 → West).
  - Neither high → IDLE.
- Latency: a request sampled at edge N gives a grant high after edge N (one-cycle request-to-grant from IDLE).
- On entering GNT_E: counter is cleared and last_e is set to 1. On entering GNT_W: counter is cleared and last_e is set to 0.
- In GNT_X, the counter increments each cycle and saturates at HOLD_CYCLES-1.
- GNT_X goes to CLEAR when either:
  - req_X is low, or
  - counter == HOLD_CYCLES-1 and the opposite request is high (preemption).
- If the opposite side is not requesting, the grant is held indefinitely while req_X stays high.
- CLEAR: both grants are 0 for exactly CLEAR_CYCLES cycles, then the arbitration decision runs.
- A requester that drops its request during CLEAR is not granted.
- Invariant: gnt_e & gnt_w is never 1. all_clear == ~(gnt_e | gnt_w) on every cycle.
- Simultaneous request release and opposite request rise: normal release to CLEAR.
- Back-to-back requests from the same side when the other side is idle: the same side is re-granted after CLEAR; round-robin applies only to ties.

Optional Feature:
- Macro: EW_ARB_STATS_EN.
- Defined:
  - grant_cnt_e / grant_cnt_w increment by 1 on each entry into GNT_E / GNT_W.
  - Both wrap modulo 2^CNT_W.
  - Both clear on rst.
- Undefined:
  - Both ports are tied to 0 and no counter flops are built.
  - Ports are still present, so the port list is identical in both builds.

Test Plan:
1. rst high for 2 cycles with req_e = 1 → gnt_e = gnt_w = 0, all_clear = 1, last_e = 0; release rst → gnt_e = 1 one edge later.
2. req_e and req_w both rise in the same cycle from IDLE → gnt_e for 4 cycles (preempted), gnt_w = 0 for the 2 CLEAR cycles, then gnt_w = 1 for 4 cycles, then gnt_e again; gnt_e & gnt_w is never 1.
3. req_e held high, req_w low, for 20 cycles → gnt_e stays high all 20 cycles with no preemption.
4. gnt_w active and req_w drops after 2 cycles, req_e low → 2 CLEAR cycles, then IDLE, all_clear = 1.
5. rst pulsed while gnt_w = 1 → gnt_w = 0 on that edge, state IDLE, last_e = 0; both requests held → East granted first.
6. With EW_ARB_STATS_EN defined, alternate ties for 300 grants per side → grant_cnt_e = grant_cnt_w = 300 mod 256 = 44. With the macro undefined, both counts read 0.

Source files
------------

// File: rtl/east_west_arbiter.sv
// Two-requester (East/West) arbiter with tenure limit, round-robin tie break and an all-clear gap.
// Optional grant statistics are built when EW_ARB_STATS_EN is defined.
module east_west_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_e,
  input  logic             req_w,
  output logic             gnt_e,
  output logic             gnt_w,
  output logic             all_clear,
  output logic             last_e,
  output logic [CNT_W-1:0] grant_cnt_e,
  output logic [CNT_W-1:0] grant_cnt_w
);

  typedef enum logic [1:0] {StIdle, StGntE, StGntW, StClear} state_e;

  localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ClearMax = CNT_W'(CLEAR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_e_q, last_e_d;
  logic             gnt_e_q, gnt_e_d;
  logic             gnt_w_q, gnt_w_d;
  logic             all_clear_q, all_clear_d;
  logic             decide;
  logic             pick_e, pick_w;

  // Ties go to the side opposite the most recent grant.
  assign pick_e = req_e & (~req_w | ~last_e_q);
  assign pick_w = req_w & (~req_e | last_e_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_e_d = last_e_q;
    decide   = 1'b0;

    unique case (state_q)
      StIdle: decide = 1'b1;
      StGntE: begin
        if (!req_e || (cnt_q == HoldMax && req_w)) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (cnt_q != HoldMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGntW: begin
        if (!req_w || (cnt_q == HoldMax && req_e)) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (cnt_q != HoldMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StClear: begin
        if (cnt_q == ClearMax) begin
          decide = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (decide) begin
      cnt_d = '0;
      if (pick_e) begin
        state_d  = StGntE;
        last_e_d = 1'b1;
      end else if (pick_w) begin
        state_d  = StGntW;
        last_e_d = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end

    gnt_e_d     = (state_d == StGntE);
    gnt_w_d     = (state_d == StGntW);
    all_clear_d = ~(gnt_e_d | gnt_w_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_e_q    <= 1'b0;
      gnt_e_q     <= 1'b0;
      gnt_w_q     <= 1'b0;
      all_clear_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_e_q    <= last_e_d;
      gnt_e_q     <= gnt_e_d;
      gnt_w_q     <= gnt_w_d;
      all_clear_q <= all_clear_d;
    end
  end

  assign gnt_e     = gnt_e_q;
  assign gnt_w     = gnt_w_q;
  assign all_clear = all_clear_q;
  assign last_e    = last_e_q;

`ifdef EW_ARB_STATS_EN
  logic [CNT_W-1:0] stat_e_q, stat_e_d;
  logic [CNT_W-1:0] stat_w_q, stat_w_d;

  // Count grant entries only; counters wrap naturally.
  always_comb begin
    stat_e_d = stat_e_q;
    stat_w_d = stat_w_q;
    if (state_d == StGntE && state_q != StGntE) stat_e_d = stat_e_q + 1'b1;
    if (state_d == StGntW && state_q != StGntW) stat_w_d = stat_w_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_e_q <= '0;
      stat_w_q <= '0;
    end else begin
      stat_e_q <= stat_e_d;
      stat_w_q <= stat_w_d;
    end
  end

  assign grant_cnt_e = stat_e_q;
  assign grant_cnt_w = stat_w_q;
`else
  assign grant_cnt_e = '0;
  assign grant_cnt_w = '0;
`endif

endmodule
